ifu_icache_fa: RTL and testbench
================================

Name: ifu_icache_fa

Overview:
- Parametrised, fully-associative instruction cache that sits between the core fetch stage and instruction memory.
- Serves 32-bit instruction fetches from WAYS_NUM lines of CL_WIDTH bits each.
- Refills a line on a miss, with one outstanding request at a time.
- Replacement uses a tree pseudo-LRU.
- Adds behaviour the previous generation lacked: invalid-way-first allocation, a whole-cache flush (fence.i), and discard of mismatched or stale refills.

Parameters:
- CL_WIDTH, 128, cache line width in bits; power of 2, ≥64.
- WAYS_NUM, 16, number of lines (ways); power of 2, ≥2.
- ADDR_WIDTH, 32, fetch address width.
- OFFSET_W, $clog2(CL_WIDTH/8), byte offset within a line (derived).
- TAG_W, ADDR_WIDTH-OFFSET_W, tag width (derived).

Ports:
- Clk  in  1  clock
- RstN  in  1  asynchronous active-low reset
- core_req_valid  in  1  fetch request valid
- core_req_pc  in  ADDR_WIDTH  fetch address, word aligned
- flush  in  1  one-cycle pulse; invalidate all lines
- core_rsp_valid  out  1  instruction valid
- core_rsp_instr  out  32  fetched instruction
- core_rsp_pc  out  ADDR_WIDTH  address of the returned instruction
- stall_pc  out  1  core holds its PC while high
- mem_req_valid  out  1  one-cycle refill request pulse
- mem_req_addr  out  ADDR_WIDTH  line-aligned refill address
- mem_rsp_valid  in  1  refill data valid
- mem_rsp_addr  in  ADDR_WIDTH  line address of the returned data
- mem_rsp_data  in  CL_WIDTH  line data

Behaviour:
Reset (RstN=0, asynchronous):
- Every valid bit and every PLRU bit is cleared; FSM goes to IDLE.
- All outputs are 0.
- Tag and data arrays are not reset.

Lookup:
- In IDLE with core_req_valid, the tag core_req_pc[ADDR_WIDTH-1:OFFSET_W] is compared against all valid ways combinationally.

Hit:
- Next cycle: core_rsp_valid=1, core_rsp_pc=pc, core_rsp_instr = word pc[OFFSET_W-1:2] of the hit line. Latency is 1 cycle.
- The PLRU is updated so the hit way becomes most recently used.
- stall_pc stays 0. Back-to-back hits sustain one per cycle.

Miss:
- stall_pc=1 in the same cycle, combinationally.
- The line address and word index are latched.
- FSM sequence: IDLE -> MISS_REQ -> WAIT_FOR_IMEM -> FILL -> IDLE.

MISS_REQ:
- mem_req_valid=1 for exactly 1 cycle, with mem_req_addr = the line-aligned pc.

WAIT_FOR_IMEM:
- Waits with no timeout.
- A mem_rsp_valid whose mem_rsp_addr differs from the latched line address is ignored.
- A matching response captures the data.

FILL:
- Victim way is the lowest-index invalid way; if none is invalid, the PLRU victim.
- Writes the tag and data, sets the valid bit, and updates the PLRU to MRU.
- Drives core_rsp_valid with the requested word from the captured data.
- Drops stall_pc the same cycle and returns to IDLE.
- Total miss latency equals memory latency + 3 cycles.

Requests while busy:
- core_req_valid outside IDLE is ignored; the core must hold its PC while stall_pc is high.

flush:
- Clears all valid bits and PLRU bits at the next edge.
- In IDLE, a request arriving in the same cycle as flush is treated as a miss.
- Flush during MISS_REQ/WAIT_FOR_IMEM/FILL sets a drop flag. The refill still returns its instruction to the core but is NOT allocated: no valid bit set, no PLRU update. The drop flag clears on return to IDLE.

PLRU:
- WAYS_NUM-1 node bits. Bit=0 means the victim lies left, 1 means right.
- Touching a way sets each node on its path to point away from it.

Reset mid-miss:
- Aborts the miss. A later mem_rsp_valid is ignored because the FSM is in IDLE.

Decomposition:
- Additions to ifu_pkg:
  - t_icache_state enum {IDLE, MISS_REQ, WAIT_FOR_IMEM, FILL}
  - PLRU node struct
  - core request/response structs
  - refill request/response structs
- Sub-module ifu_plru_tree (parameter WAYS_NUM):
  - inputs: touch_valid, touch_way, clear
  - output: victim_way
  - holds its own node register with asynchronous reset

Test Plan (WAYS_NUM=4, CL_WIDTH=128):
- Cold miss: request pc 0x100, memory returns line 0x100 after 5 cycles -> one mem_req_valid pulse with addr 0x100; stall_pc high for 8 cycles; core_rsp_instr = word 0 of the line; way0 valid.
- Hit: after the cold miss, request pc 0x10C -> core_rsp_valid next cycle with word 3, no mem_req, stall_pc=0.
- Eviction: fill lines 0x000, 0x010, 0x020, 0x030, touch 0x000, then miss 0x040 -> victim is way2 (the line at 0x020); a re-fetch of 0x000 hits.
- Flush mid-miss: flush pulsed during WAIT_FOR_IMEM for 0x200 -> instruction is delivered, but a re-fetch of 0x200 misses and all valid bits are 0.
- Mismatch: memory returns addr 0x300 while 0x200 is pending, then 0x200 -> first response ignored; the second fills, and only 0x200 is valid.
- Reset: RstN low during WAIT_FOR_IMEM -> outputs are 0 immediately; a late mem_rsp is ignored; the next fetch misses.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types for the instruction-fetch unit.
// Holds the I-cache FSM state encoding, the PLRU node type and the
// request/response bundle layouts for the core and refill interfaces.
// Bundle widths use the default cache geometry.
package ifu_pkg;

  localparam int IFU_ADDR_W  = 32;
  localparam int IFU_INSTR_W = 32;
  localparam int IFU_CL_W    = 128;

  typedef enum logic [1:0] {
    IDLE,
    MISS_REQ,
    WAIT_FOR_IMEM,
    FILL
  } t_icache_state;

  // One tree node: 0 = victim lies in the left subtree, 1 = right subtree.
  typedef struct packed {
    logic victim_right;
  } t_plru_node;

  typedef struct packed {
    logic                  valid;
    logic [IFU_ADDR_W-1:0] pc;
  } t_core_req;

  typedef struct packed {
    logic                   valid;
    logic [IFU_INSTR_W-1:0] instr;
    logic [IFU_ADDR_W-1:0]  pc;
  } t_core_rsp;

  typedef struct packed {
    logic                  valid;
    logic [IFU_ADDR_W-1:0] addr;
  } t_refill_req;

  typedef struct packed {
    logic                  valid;
    logic [IFU_ADDR_W-1:0] addr;
    logic [IFU_CL_W-1:0]   data;
  } t_refill_rsp;

endpackage

// File: rtl/ifu_plru_tree.sv
// Tree pseudo-LRU for a fully-associative set of WAYS_NUM ways.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset (clears all nodes)
//   touch_valid   mark touch_way as most recently used at the next edge
//   touch_way     way being accessed
//   clear         clear all nodes at the next edge (wins over touch)
//   victim_way    way the tree currently points at
// Nodes are stored level by level: level l starts at flat index 2^l-1.
module ifu_plru_tree
  import ifu_pkg::*;
#(
  parameter int WAYS_NUM = 16,
  parameter int WAY_W    = $clog2(WAYS_NUM)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             touch_valid,
  input  logic [WAY_W-1:0] touch_way,
  input  logic             clear,
  output logic [WAY_W-1:0] victim_way
);

  t_plru_node [WAYS_NUM-2:0] nodes_reg;
  t_plru_node [WAYS_NUM-2:0] nodes_next;
  logic [WAY_W-1:0] vic_pos;
  logic [WAY_W-1:0] vic_sel;
  logic [WAY_W-1:0] touch_shift;
  logic [WAY_W-1:0] touch_sel;

  // Walk from the root; each visited node contributes one bit of the way index.
  always_comb begin
    vic_pos = '0;
    vic_sel = '0;
    for (int l = 0; l < WAY_W; l++) begin
      vic_sel = WAY_W'((1 << l) - 1) + vic_pos;
      vic_pos = (vic_pos << 1) | WAY_W'(nodes_reg[vic_sel].victim_right);
    end
  end

  assign victim_way = vic_pos;

  // Every node on the touched way's path is pointed at the opposite subtree.
  always_comb begin
    nodes_next  = nodes_reg;
    touch_shift = '0;
    touch_sel   = '0;
    for (int l = 0; l < WAY_W; l++) begin
      touch_shift = touch_way >> (WAY_W - 1 - l);
      touch_sel   = WAY_W'((1 << l) - 1) + (touch_shift >> 1);
      nodes_next[touch_sel].victim_right = ~touch_shift[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nodes_reg <= '0;
    end else if (clear) begin
      nodes_reg <= '0;
    end else if (touch_valid) begin
      nodes_reg <= nodes_next;
    end
  end

endmodule

// File: rtl/ifu_icache_fa.sv
// Fully-associative instruction cache between fetch and instruction memory.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   core_req_valid/pc          fetch request (pc word aligned)
//   flush                      one-cycle pulse, invalidates every line
//   core_rsp_valid/instr/pc    returned instruction (hit: 1 cycle later;
//                              miss: during the FILL cycle)
//   stall_pc                   core must hold its PC while high
//   mem_req_valid/addr         one-cycle line refill request
//   mem_rsp_valid/addr/data    refill data; only the pending line is accepted
module ifu_icache_fa
  import ifu_pkg::*;
#(
  parameter int CL_WIDTH   = 128,
  parameter int WAYS_NUM   = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int OFFSET_W   = $clog2(CL_WIDTH / 8),
  parameter int TAG_W      = ADDR_WIDTH - OFFSET_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  core_req_valid,
  input  logic [ADDR_WIDTH-1:0] core_req_pc,
  input  logic                  flush,
  output logic                  core_rsp_valid,
  output logic [31:0]           core_rsp_instr,
  output logic [ADDR_WIDTH-1:0] core_rsp_pc,
  output logic                  stall_pc,
  output logic                  mem_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [ADDR_WIDTH-1:0] mem_rsp_addr,
  input  logic [CL_WIDTH-1:0]   mem_rsp_data
);

  localparam int WAY_W  = $clog2(WAYS_NUM);
  localparam int WORD_W = OFFSET_W - 2;

  t_icache_state state_reg, state_next;
  logic [WAYS_NUM-1:0]   valid_reg;
  logic [TAG_W-1:0]      tag_arr  [WAYS_NUM];
  logic [CL_WIDTH-1:0]   data_arr [WAYS_NUM];
  logic [ADDR_WIDTH-1:0] miss_pc_reg;
  logic [CL_WIDTH-1:0]   fill_data_reg;
  logic                  drop_reg;
  logic                  rsp_valid_reg;
  logic [31:0]           rsp_instr_reg;
  logic [ADDR_WIDTH-1:0] rsp_pc_reg;

  logic [TAG_W-1:0]    req_tag, miss_tag;
  logic [WORD_W-1:0]   req_word, miss_word;
  logic [WAYS_NUM-1:0] hit_vec;
  logic [WAY_W-1:0]    hit_way, inv_way, plru_victim, fill_way, touch_way;
  logic                inv_any, lookup, hit, miss, rsp_match, alloc, touch_valid;

  assign req_tag   = core_req_pc[ADDR_WIDTH-1:OFFSET_W];
  assign req_word  = core_req_pc[OFFSET_W-1:2];
  assign miss_tag  = miss_pc_reg[ADDR_WIDTH-1:OFFSET_W];
  assign miss_word = miss_pc_reg[OFFSET_W-1:2];

  for (genvar gi = 0; gi < WAYS_NUM; gi++) begin : g_tag_cmp
    assign hit_vec[gi] = valid_reg[gi] && (tag_arr[gi] == req_tag);
  end

  always_comb begin
    hit_way = '0;
    for (int i = 0; i < WAYS_NUM; i++) begin
      if (hit_vec[i]) hit_way = WAY_W'(i);
    end
  end

  // Descending scan so the lowest-index invalid way wins.
  always_comb begin
    inv_way = '0;
    for (int i = WAYS_NUM - 1; i >= 0; i--) begin
      if (!valid_reg[i]) inv_way = WAY_W'(i);
    end
  end

  assign inv_any  = ~&valid_reg;
  assign fill_way = inv_any ? inv_way : plru_victim;

  // A flush in the lookup cycle wipes the hit line, so the request misses.
  assign lookup    = (state_reg == IDLE) && core_req_valid;
  assign hit       = lookup && (|hit_vec) && !flush;
  assign miss      = lookup && !hit;
  assign rsp_match = (state_reg == WAIT_FOR_IMEM) && mem_rsp_valid &&
                     (mem_rsp_addr == {miss_tag, {OFFSET_W{1'b0}}});
  // A flush seen at any point of the miss makes the refilled line stale.
  assign alloc       = (state_reg == FILL) && !drop_reg && !flush;
  assign touch_valid = hit || alloc;
  assign touch_way   = (state_reg == FILL) ? fill_way : hit_way;

  always_comb begin
    state_next    = state_reg;
    stall_pc      = 1'b0;
    mem_req_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        stall_pc = miss;
        if (miss) state_next = MISS_REQ;
      end
      MISS_REQ: begin
        stall_pc      = 1'b1;
        mem_req_valid = 1'b1;
        state_next    = WAIT_FOR_IMEM;
      end
      WAIT_FOR_IMEM: begin
        stall_pc = 1'b1;
        if (rsp_match) state_next = FILL;
      end
      FILL:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Keep every output low while reset is asserted, even with a request present.
    if (!rst_n) stall_pc = 1'b0;
  end

  assign mem_req_addr   = mem_req_valid ? {miss_tag, {OFFSET_W{1'b0}}} : '0;
  assign core_rsp_valid = rsp_valid_reg || (state_reg == FILL);
  assign core_rsp_instr = (state_reg == FILL) ? fill_data_reg[{miss_word, 5'b0} +: 32]
                                              : rsp_instr_reg;
  assign core_rsp_pc    = (state_reg == FILL) ? miss_pc_reg : rsp_pc_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      valid_reg     <= '0;
      drop_reg      <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_instr_reg <= '0;
      rsp_pc_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      rsp_valid_reg <= hit;
      if (hit) begin
        rsp_instr_reg <= data_arr[hit_way][{req_word, 5'b0} +: 32];
        rsp_pc_reg    <= core_req_pc;
      end
      if (state_reg == FILL) begin
        drop_reg <= 1'b0;
      end else if (flush && state_reg != IDLE) begin
        drop_reg <= 1'b1;
      end
      if (flush) begin
        valid_reg <= '0;
      end else if (alloc) begin
        valid_reg[fill_way] <= 1'b1;
      end
    end
  end

  // Tag/data storage and miss bookkeeping carry no reset.
  always_ff @(posedge clk) begin
    if (miss) miss_pc_reg <= core_req_pc;
    if (rsp_match) fill_data_reg <= mem_rsp_data;
    if (alloc) begin
      tag_arr[fill_way]  <= miss_tag;
      data_arr[fill_way] <= fill_data_reg;
    end
  end

  ifu_plru_tree #(
    .WAYS_NUM(WAYS_NUM),
    .WAY_W   (WAY_W)
  ) u_plru (
    .clk        (clk),
    .rst_n      (rst_n),
    .touch_valid(touch_valid),
    .touch_way  (touch_way),
    .clear      (flush),
    .victim_way (plru_victim)
  );

endmodule

// File: tb/tb_ifu_icache_fa.sv
// Directed bench for ifu_icache_fa (4 ways, 128-bit lines). Expected fetch
// responses go into a scoreboard queue when a fetch is issued and are popped
// by a monitor whenever the cache returns an instruction.
module tb_ifu_icache_fa;

  localparam int CL   = 128;
  localparam int WAYS = 4;
  localparam int AW   = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          core_req_valid = 1'b0;
  logic [AW-1:0] core_req_pc = '0;
  logic          flush = 1'b0;
  logic          core_rsp_valid;
  logic [31:0]   core_rsp_instr;
  logic [AW-1:0] core_rsp_pc;
  logic          stall_pc;
  logic          mem_req_valid;
  logic [AW-1:0] mem_req_addr;
  logic          mem_rsp_valid = 1'b0;
  logic [AW-1:0] mem_rsp_addr = '0;
  logic [CL-1:0] mem_rsp_data = '0;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] sb_q[$];
  logic [63:0] sb_exp;

  always #5 clk = ~clk;

  ifu_icache_fa #(
    .CL_WIDTH  (CL),
    .WAYS_NUM  (WAYS),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .core_req_valid(core_req_valid),
    .core_req_pc   (core_req_pc),
    .flush         (flush),
    .core_rsp_valid(core_rsp_valid),
    .core_rsp_instr(core_rsp_instr),
    .core_rsp_pc   (core_rsp_pc),
    .stall_pc      (stall_pc),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_addr  (mem_rsp_addr),
    .mem_rsp_data  (mem_rsp_data)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE0000 ^ (a * 32'h9E3779B1);
  endfunction

  function automatic logic [CL-1:0] mem_line(input logic [31:0] la);
    logic [CL-1:0] d;
    d = '0;
    for (int w = 0; w < 4; w++) d[w*32 +: 32] = mem_word(la + 32'(w * 4));
    return d;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every returned instruction must match the oldest expectation.
  always @(negedge clk) begin
    if (core_rsp_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rsp_valid", 128'(core_rsp_valid), 128'(0));
      end else begin
        sb_exp = sb_q.pop_front();
        check("rsp_pc_instr", 128'({core_rsp_pc, core_rsp_instr}), 128'(sb_exp));
      end
    end
  end

  // One fetch from the core side with a simple memory model answering refills.
  // lat: response arrives lat+1 cycles after the mem_req cycle.
  task automatic fetch(input logic [31:0] pc, input int lat, input int exp_stall,
                       input int exp_reqs, input int flush_at, input bit send_wrong,
                       input logic [31:0] wrong_addr);
    int cyc = 0;
    int due = -100;
    int stall_cnt = 0;
    int req_cnt = 0;
    bit accepted = 1'b0;
    bit finished = 1'b0;
    logic [31:0] la;
    la = pc & 32'hFFFF_FFF0;
    sb_q.push_back({pc, mem_word(pc)});
    core_req_valid = 1'b1;
    core_req_pc    = pc;
    while (!finished && cyc < 200) begin
      flush = (cyc == flush_at);
      if (send_wrong && cyc == due) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_addr  = wrong_addr;
        mem_rsp_data  = mem_line(wrong_addr);
      end else if (cyc == due + (send_wrong ? 2 : 0)) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_addr  = la;
        mem_rsp_data  = mem_line(la);
      end else begin
        mem_rsp_valid = 1'b0;
      end
      @(negedge clk);
      if (stall_pc) stall_cnt++;
      else if (core_req_valid) accepted = 1'b1;
      if (mem_req_valid) begin
        req_cnt++;
        check("mem_req_addr", 128'(mem_req_addr), 128'(la));
        due = cyc + lat + 1;
      end
      if (core_rsp_valid) finished = 1'b1;
      @(posedge clk); #1;
      if (accepted) core_req_valid = 1'b0;
      cyc++;
    end
    flush = 1'b0;
    mem_rsp_valid = 1'b0;
    core_req_valid = 1'b0;
    check("rsp_within_budget", 128'(finished), 128'(1));
    check("stall_cycles", 128'(stall_cnt), 128'(exp_stall));
    check("mem_req_count", 128'(req_cnt), 128'(exp_reqs));
    $display("fetch pc=%08h stall=%0d mem_reqs=%0d cycles=%0d", pc, stall_cnt, req_cnt, cyc);
  endtask

  task automatic do_reset();
    core_req_valid = 1'b0;
    flush = 1'b0;
    mem_rsp_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic quiet;
    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("reset_outputs", 128'({core_rsp_valid, stall_pc, mem_req_valid, core_rsp_instr,
                                 core_rsp_pc, mem_req_addr}), 128'(0));
    check("reset_valid", 128'(dut.valid_reg), 128'(0));
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Cold miss then hit in the same line
    fetch(32'h100, 5, 8, 1, -1, 1'b0, 32'h0);
    check("cold_valid", 128'(dut.valid_reg), 128'(4'b0001));
    fetch(32'h10C, 5, 0, 0, -1, 1'b0, 32'h0);

    // Eviction: fill all four ways, touch way0, miss evicts way2
    do_reset();
    fetch(32'h000, 2, 5, 1, -1, 1'b0, 32'h0);
    fetch(32'h010, 2, 5, 1, -1, 1'b0, 32'h0);
    fetch(32'h020, 2, 5, 1, -1, 1'b0, 32'h0);
    fetch(32'h030, 2, 5, 1, -1, 1'b0, 32'h0);
    check("full_valid", 128'(dut.valid_reg), 128'(4'b1111));
    fetch(32'h000, 2, 0, 0, -1, 1'b0, 32'h0);
    fetch(32'h040, 2, 5, 1, -1, 1'b0, 32'h0);
    fetch(32'h004, 2, 0, 0, -1, 1'b0, 32'h0);
    fetch(32'h018, 2, 0, 0, -1, 1'b0, 32'h0);
    fetch(32'h03C, 2, 0, 0, -1, 1'b0, 32'h0);
    fetch(32'h044, 2, 0, 0, -1, 1'b0, 32'h0);
    fetch(32'h028, 2, 5, 1, -1, 1'b0, 32'h0);

    // Flush during WAIT_FOR_IMEM: instruction delivered, line not allocated
    do_reset();
    fetch(32'h000, 5, 8, 1, -1, 1'b0, 32'h0);
    fetch(32'h200, 5, 8, 1, 3, 1'b0, 32'h0);
    check("flush_mid_miss_valid", 128'(dut.valid_reg), 128'(0));
    fetch(32'h200, 5, 8, 1, -1, 1'b0, 32'h0);
    check("refetch_after_flush_valid", 128'(dut.valid_reg), 128'(4'b0001));

    // Mismatched refill address is ignored
    do_reset();
    fetch(32'h200, 5, 10, 1, -1, 1'b1, 32'h300);
    check("mismatch_valid", 128'(dut.valid_reg), 128'(4'b0001));
    fetch(32'h204, 5, 0, 0, -1, 1'b0, 32'h0);

    // Flush in the same cycle as a request that would hit: treated as a miss
    fetch(32'h208, 5, 8, 1, 0, 1'b0, 32'h0);
    check("flush_same_cycle_valid", 128'(dut.valid_reg), 128'(4'b0001));

    // Reset during WAIT_FOR_IMEM
    core_req_valid = 1'b1;
    core_req_pc    = 32'h400;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("wait_stall", 128'(stall_pc), 128'(1));
    @(posedge clk); #1;
    rst_n = 1'b0;
    core_req_valid = 1'b0;
    #1;
    check("reset_mid_miss_outputs", 128'({core_rsp_valid, stall_pc, mem_req_valid,
                                          core_rsp_instr, core_rsp_pc, mem_req_addr}), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_addr  = 32'h400;
    mem_rsp_data  = mem_line(32'h400);
    quiet = 1'b0;
    @(negedge clk);
    quiet = quiet | core_rsp_valid | stall_pc | mem_req_valid;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      quiet = quiet | core_rsp_valid | stall_pc | mem_req_valid;
    end
    check("late_rsp_ignored", 128'(quiet), 128'(0));
    check("late_rsp_valid", 128'(dut.valid_reg), 128'(0));
    @(posedge clk); #1;
    fetch(32'h400, 3, 6, 1, -1, 1'b0, 32'h0);

    check("scoreboard_drained", 128'(sb_q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
